// File: rtl/capi_command_arbiter.sv
// -----------------------------------------------------------------------------
// capi_command_arbiter
//
// Shares one PSL command interface between NUM_REQ work elements. Requests
// are granted round-robin and each grant takes the lowest free tag from a pool
// of NUM_TAGS. The tag's owner is recorded so that the PSL response for the tag
// can be routed back to the requester that issued it. PSL command credits are
// loaded from croom when the arbiter starts and are then adjusted by response
// credit returns and by issued commands.
//
// Ports
//   clock, reset                 : clock, asynchronous active-low reset
//   enabled                      : level, high = accept and issue commands
//   croom                        : PSL command credits, loaded on IDLE->RUN
//   req_valid/command/address/size : per-requester command request (packed)
//   req_ready                    : one-hot combinational grant
//   command_*                    : registered PSL command bus, odd parity
//   response_*                   : PSL response bus
//   resp_out_valid/code/tag      : response routed to the owning requester
//   busy                         : not IDLE, or tags still outstanding
//   tag_error                    : sticky, response for an unallocated tag
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | stopped, no tags outstanding; credits reload when enabled rises
// RUN   | granting requests while credits and free tags allow
// DRAIN | disabled; no grants, waiting for outstanding responses
// -----------------------------------------------------------------------------
module capi_command_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int NUM_TAGS = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enabled,
   input  logic [7:0]              croom,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [13*NUM_REQ-1:0]   req_command,
   input  logic [64*NUM_REQ-1:0]   req_address,
   input  logic [12*NUM_REQ-1:0]   req_size,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    command_valid,
   output logic [12:0]             command_command,
   output logic [63:0]             command_address,
   output logic [11:0]             command_size,
   output logic [7:0]              command_tag,
   output logic                    command_command_parity,
   output logic                    command_address_parity,
   output logic                    command_tag_parity,
   output logic [2:0]              command_abt,
   output logic [15:0]             command_context_handle,
   input  logic                    response_valid,
   input  logic [7:0]              response_tag,
   input  logic [7:0]              response_code,
   input  logic signed [8:0]       response_credits,
   output logic [NUM_REQ-1:0]      resp_out_valid,
   output logic [7:0]              resp_out_code,
   output logic [7:0]              resp_out_tag,
   output logic                    busy,
   output logic                    tag_error
);

   localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TAG_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
   localparam logic [8:0] TAG_LIMIT = 9'(NUM_TAGS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic signed [8:0]     credits, credits_nxt;
   logic [REQ_W-1:0]      rr_ptr;
   logic [NUM_TAGS-1:0]   tag_busy;
   logic [REQ_W-1:0]      tag_owner [NUM_TAGS];

   logic                  upper_found, lower_found;
   logic [REQ_W-1:0]      upper_idx, lower_idx;
   logic                  gnt_found;
   logic [REQ_W-1:0]      gnt_idx;
   logic                  tag_free_found;
   logic [TAG_W-1:0]      tag_free_idx;
   logic                  credits_pos;
   logic                  grant;
   logic [12:0]           sel_command;
   logic [63:0]           sel_address;
   logic [11:0]           sel_size;

   logic                  resp_in_range;
   logic [TAG_W-1:0]      resp_tag_idx;
   logic                  resp_hit;
   logic                  resp_err;
   logic signed [8:0]     resp_cr;
   logic signed [8:0]     gnt_dec;

   // Round-robin search: the requester closest at or above rr_ptr wins;
   // otherwise wrap around to the lowest requester below rr_ptr.
   always_comb begin
      upper_found = 1'b0;
      upper_idx   = '0;
      lower_found = 1'b0;
      lower_idx   = '0;
      for (int r = NUM_REQ - 1; r >= 0; r--) begin
         if (req_valid[r]) begin
            if (REQ_W'(r) >= rr_ptr) begin
               upper_found = 1'b1;
               upper_idx   = REQ_W'(r);
            end else begin
               lower_found = 1'b1;
               lower_idx   = REQ_W'(r);
            end
         end
      end
      gnt_found = upper_found | lower_found;
      gnt_idx   = upper_found ? upper_idx : lower_idx;
   end

   // Lowest-index free tag. Uses the registered pool, so a tag freed by a
   // response this cycle only becomes grantable on the next cycle.
   always_comb begin
      tag_free_found = 1'b0;
      tag_free_idx   = '0;
      for (int t = NUM_TAGS - 1; t >= 0; t--) begin
         if (!tag_busy[t]) begin
            tag_free_found = 1'b1;
            tag_free_idx   = TAG_W'(t);
         end
      end
   end

   assign credits_pos = (credits > 9'sd0);
   assign grant       = (state == ST_RUN) && gnt_found && credits_pos && tag_free_found;

   always_comb begin
      req_ready   = '0;
      sel_command = '0;
      sel_address = '0;
      sel_size    = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (REQ_W'(r) == gnt_idx) begin
            req_ready[r] = grant;
            sel_command  = req_command[r*13 +: 13];
            sel_address  = req_address[r*64 +: 64];
            sel_size     = req_size[r*12 +: 12];
         end
      end
   end

   // Response decode: tags beyond the pool or not currently allocated are errors.
   assign resp_in_range = ({1'b0, response_tag} < TAG_LIMIT);
   assign resp_tag_idx  = response_tag[TAG_W-1:0];
   assign resp_hit      = response_valid && resp_in_range && tag_busy[resp_tag_idx];
   assign resp_err      = response_valid && !resp_hit;

   assign resp_cr = response_valid ? response_credits : 9'sd0;
   assign gnt_dec = grant ? 9'sd1 : 9'sd0;

   always_comb begin
      state_nxt   = state;
      credits_nxt = credits + resp_cr - gnt_dec;
      case (state)
         ST_IDLE: begin
            if (enabled) begin
               state_nxt   = ST_RUN;
               credits_nxt = $signed({1'b0, croom});
            end
         end
         ST_RUN: begin
            if (!enabled) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (enabled)            state_nxt = ST_RUN;
            else if (tag_busy == '0) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         credits <= '0;
         rr_ptr  <= '0;
      end else begin
         state   <= state_nxt;
         credits <= credits_nxt;
         if (grant) begin
            rr_ptr <= (gnt_idx == REQ_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   // Tag pool and owner table. A response frees one tag and a grant claims a
   // different (currently free) one, so both may update on the same edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tag_busy <= '0;
         for (int t = 0; t < NUM_TAGS; t++) begin
            tag_owner[t] <= '0;
         end
      end else begin
         if (resp_hit) begin
            tag_busy[resp_tag_idx] <= 1'b0;
         end
         if (grant) begin
            tag_busy[tag_free_idx]  <= 1'b1;
            tag_owner[tag_free_idx] <= gnt_idx;
         end
      end
   end

   // Command bus: one-cycle valid after the grant, fields hold otherwise.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         command_valid   <= 1'b0;
         command_command <= '0;
         command_address <= '0;
         command_size    <= '0;
         command_tag     <= '0;
      end else begin
         command_valid <= grant;
         if (grant) begin
            command_command <= sel_command;
            command_address <= sel_address;
            command_size    <= sel_size;
            command_tag     <= 8'(tag_free_idx);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         resp_out_valid <= '0;
         resp_out_code  <= '0;
         resp_out_tag   <= '0;
         tag_error      <= 1'b0;
      end else begin
         resp_out_valid <= '0;
         if (resp_hit) begin
            resp_out_valid[tag_owner[resp_tag_idx]] <= 1'b1;
            resp_out_code                           <= response_code;
            resp_out_tag                            <= response_tag;
         end
         if (resp_err) begin
            tag_error <= 1'b1;
         end
      end
   end

   assign busy = (state != ST_IDLE) || (|tag_busy);

   assign command_command_parity = ~^command_command;
   assign command_address_parity = ~^command_address;
   assign command_tag_parity     = ~^command_tag;
   assign command_abt            = '0;
   assign command_context_handle = '0;

endmodule

// File: tb/tb_capi_command_arbiter.sv
module tb_capi_command_arbiter;

   localparam int NR = 2;
   localparam int NT = 16;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 enabled = 1'b0;
   logic [7:0]           croom = '0;
   logic [NR-1:0]        req_valid = '0;
   logic [13*NR-1:0]     req_command = '0;
   logic [64*NR-1:0]     req_address = '0;
   logic [12*NR-1:0]     req_size = '0;
   logic [NR-1:0]        req_ready;
   logic                 command_valid;
   logic [12:0]          command_command;
   logic [63:0]          command_address;
   logic [11:0]          command_size;
   logic [7:0]           command_tag;
   logic                 command_command_parity;
   logic                 command_address_parity;
   logic                 command_tag_parity;
   logic [2:0]           command_abt;
   logic [15:0]          command_context_handle;
   logic                 response_valid = 1'b0;
   logic [7:0]           response_tag = '0;
   logic [7:0]           response_code = '0;
   logic signed [8:0]    response_credits = '0;
   logic [NR-1:0]        resp_out_valid;
   logic [7:0]           resp_out_code;
   logic [7:0]           resp_out_tag;
   logic                 busy;
   logic                 tag_error;

   capi_command_arbiter #(.NUM_REQ(NR), .NUM_TAGS(NT)) dut (
      .clock                  (clock),
      .reset                  (reset),
      .enabled                (enabled),
      .croom                  (croom),
      .req_valid              (req_valid),
      .req_command            (req_command),
      .req_address            (req_address),
      .req_size               (req_size),
      .req_ready              (req_ready),
      .command_valid          (command_valid),
      .command_command        (command_command),
      .command_address        (command_address),
      .command_size           (command_size),
      .command_tag            (command_tag),
      .command_command_parity (command_command_parity),
      .command_address_parity (command_address_parity),
      .command_tag_parity     (command_tag_parity),
      .command_abt            (command_abt),
      .command_context_handle (command_context_handle),
      .response_valid         (response_valid),
      .response_tag           (response_tag),
      .response_code          (response_code),
      .response_credits       (response_credits),
      .resp_out_valid         (resp_out_valid),
      .resp_out_code          (resp_out_code),
      .resp_out_tag           (resp_out_tag),
      .busy                   (busy),
      .tag_error              (tag_error)
   );

   always #5 clock = ~clock;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: spec-level bookkeeping with plain integers and arrays.
   int          m_state;   // 0 = IDLE, 1 = RUN, 2 = DRAIN
   int          m_cred;
   int          m_rr;
   bit          m_busy [NT];
   int          m_owner [NT];
   bit          m_tag_error;
   bit          m_cvalid;
   logic [12:0] m_cmd;
   logic [63:0] m_addr;
   logic [11:0] m_size;
   logic [7:0]  m_tag;
   logic [NR-1:0] m_rov;
   logic [7:0]  m_rcode;
   logic [7:0]  m_rtag;

   int q_gnt_req [$];
   int q_gnt_tag [$];

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   function automatic logic odd_par(input logic [63:0] v);
      return ($countones(v) % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   function automatic bit any_busy();
      for (int t = 0; t < NT; t++) if (m_busy[t]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_state = 0; m_cred = 0; m_rr = 0; m_tag_error = 0; m_cvalid = 0;
      m_cmd = '0; m_addr = '0; m_size = '0; m_tag = '0;
      m_rov = '0; m_rcode = '0; m_rtag = '0;
      for (int t = 0; t < NT; t++) begin m_busy[t] = 0; m_owner[t] = 0; end
   endtask

   task automatic predict(output int g_req, output int g_tag);
      int r;
      g_req = -1;
      g_tag = -1;
      if (m_state == 1 && m_cred > 0) begin
         for (int t = 0; t < NT; t++) if (!m_busy[t]) begin g_tag = t; break; end
         if (g_tag >= 0) begin
            for (int k = 0; k < NR; k++) begin
               r = (m_rr + k) % NR;
               if (req_valid[r]) begin g_req = r; break; end
            end
         end
         if (g_req < 0) g_tag = -1;
      end
   endtask

   task automatic model_edge(input int g_req, input int g_tag);
      bit pre_busy;
      pre_busy = any_busy();
      m_rov = '0;
      if (response_valid) begin
         if (response_tag < NT && m_busy[response_tag]) begin
            m_busy[response_tag] = 0;
            m_rov[m_owner[response_tag]] = 1'b1;
            m_rcode = response_code;
            m_rtag  = response_tag;
         end else begin
            m_tag_error = 1;
         end
      end
      m_cvalid = (g_req >= 0);
      if (g_req >= 0) begin
         m_busy[g_tag]  = 1;
         m_owner[g_tag] = g_req;
         m_cmd  = req_command[g_req*13 +: 13];
         m_addr = req_address[g_req*64 +: 64];
         m_size = req_size[g_req*12 +: 12];
         m_tag  = 8'(g_tag);
         m_rr   = (g_req + 1) % NR;
      end
      if (m_state == 0 && enabled)
         m_cred = croom;
      else
         m_cred = m_cred + (response_valid ? int'(response_credits) : 0) - ((g_req >= 0) ? 1 : 0);
      case (m_state)
         0: if (enabled) m_state = 1;
         1: if (!enabled) m_state = 2;
         default: if (enabled) m_state = 1; else if (!pre_busy) m_state = 0;
      endcase
   endtask

   // One clock cycle: inputs are already driven (at the falling edge).
   task automatic step();
      int g_req, g_tag;
      logic [NR-1:0] exp_rdy;
      #1;
      predict(g_req, g_tag);
      exp_rdy = '0;
      if (g_req >= 0) exp_rdy[g_req] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      for (int r = 0; r < NR; r++) if (req_ready[r]) q_gnt_req.push_back(r);
      @(posedge clock);
      model_edge(g_req, g_tag);
      @(negedge clock);
      chk("command_valid", command_valid, m_cvalid);
      chk("command_command", command_command, m_cmd);
      chk("command_address", command_address, m_addr);
      chk("command_size", command_size, m_size);
      chk("command_tag", command_tag, m_tag);
      chk("cmd_parity", command_command_parity, odd_par(64'(m_cmd)));
      chk("addr_parity", command_address_parity, odd_par(m_addr));
      chk("tag_parity", command_tag_parity, odd_par(64'(m_tag)));
      chk("resp_out_valid", resp_out_valid, m_rov);
      if (m_rov != '0) begin
         chk("resp_out_code", resp_out_code, m_rcode);
         chk("resp_out_tag", resp_out_tag, m_rtag);
      end
      chk("tag_error", tag_error, m_tag_error);
      chk("busy", busy, (m_state != 0) || any_busy());
      if (command_valid) q_gnt_tag.push_back(int'(command_tag));
   endtask

   task automatic do_reset();
      req_valid = '0; response_valid = 1'b0; enabled = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("rst_command_valid", command_valid, 0);
      chk("rst_command_fields", {command_command, command_size, command_tag}, 0);
      chk("rst_command_address", command_address, 0);
      chk("rst_parities", {command_command_parity, command_address_parity, command_tag_parity}, 3'b111);
      chk("rst_abt_ctx", {command_abt, command_context_handle}, 0);
      chk("rst_resp_out", {resp_out_valid, resp_out_code, resp_out_tag}, 0);
      chk("rst_tag_error", tag_error, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic set_resp(input bit v, input int tag, input int cr);
      response_valid   = v;
      response_tag     = 8'(tag);
      response_code    = 8'($urandom);
      response_credits = 9'(cr);
   endtask

   initial begin
      model_reset();
      do_reset();

      // Scenario: croom=4, both requesters held -> 0,1,0,1 on tags 0..3, then stall.
      req_command = {13'h0AAA, 13'h1555};
      req_address = {64'hDEAD_BEEF_0000_1111, 64'h1234_5678_9ABC_DEF0};
      req_size    = {12'h080, 12'h040};
      croom = 8'd4; enabled = 1'b1; req_valid = 2'b11;
      q_gnt_req.delete(); q_gnt_tag.delete();
      repeat (8) step();
      chk("s1_ngrants", q_gnt_tag.size(), 4);
      for (int i = 0; i < 4 && i < q_gnt_tag.size(); i++) begin
         chk("s1_tag_seq", q_gnt_tag[i], i);
         chk("s1_req_seq", q_gnt_req[i], i % 2);
      end

      // Response for tag 1 with one credit -> routed to requester 1, tag 1 reused.
      set_resp(1, 1, 1);
      step();
      set_resp(0, 0, 0);
      chk("s2_route", resp_out_valid, 2'b10);
      step();
      chk("s2_regrant_valid", command_valid, 1);
      chk("s2_regrant_tag", command_tag, 1);

      // Grant and credit return in the same cycle at credits=1.
      set_resp(1, 0, 1);
      step();
      set_resp(1, 2, 1);
      step();
      set_resp(0, 0, 0);
      chk("s4_grant_tag0", command_tag, 0);
      step();
      chk("s4_credit_kept", command_valid, 1);
      chk("s4_grant_tag2", command_tag, 2);
      step();
      chk("s4_stall", command_valid, 0);

      // Response to never-issued tag 7.
      set_resp(1, 7, 1);
      step();
      set_resp(0, 0, 0);
      chk("s5_tag_error", tag_error, 1);
      chk("s5_no_route", resp_out_valid, 0);
      step();
      chk("s5_credit_used_tag", command_tag, 4);

      // Drain with three tags outstanding.
      set_resp(1, 0, 0); step();
      set_resp(1, 1, 0); step();
      set_resp(0, 0, 0);
      enabled = 1'b0;
      step();
      chk("s6_busy_drain", busy, 1);
      set_resp(1, 2, 1); step();
      set_resp(1, 3, 1); step();
      set_resp(1, 4, 1); step();
      set_resp(0, 0, 0);
      repeat (2) step();
      chk("s6_idle_busy", busy, 0);

      // Reset while tags are outstanding.
      croom = 8'd3; enabled = 1'b1; req_valid = 2'b11;
      repeat (4) step();
      chk("s7_outstanding", busy, 1);
      do_reset();
      step();
      chk("s7_no_resp", resp_out_valid, 0);

      // Pool-full: one requester, plenty of credits.
      croom = 8'd255; enabled = 1'b1; req_valid = 2'b01;
      q_gnt_req.delete(); q_gnt_tag.delete();
      repeat (20) step();
      chk("s3_pool_grants", q_gnt_tag.size(), 16);
      if (q_gnt_tag.size() > 0) chk("s3_first_tag", q_gnt_tag[0], 0);
      set_resp(1, 5, 0); step();
      set_resp(0, 0, 0);
      repeat (4) step();
      chk("s3_one_more", q_gnt_tag.size(), 17);
      if (q_gnt_tag.size() > 0) chk("s3_reuse_tag", q_gnt_tag[$], 5);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         int busy_list [$];
         int cr;
         enabled   = ($urandom_range(0, 15) != 0);
         req_valid = NR'($urandom);
         croom     = 8'($urandom_range(0, 8));
         for (int r = 0; r < NR; r++) begin
            req_command[r*13 +: 13] = 13'($urandom);
            req_address[r*64 +: 64] = {$urandom, $urandom};
            req_size[r*12 +: 12]    = 12'($urandom);
         end
         busy_list.delete();
         for (int t = 0; t < NT; t++) if (m_busy[t]) busy_list.push_back(t);
         cr = int'($urandom_range(0, 3));
         if (cr == 3) cr = -1;
         if (m_cred > 100) cr = 0;
         if (m_cred < -100) cr = 1;
         if ($urandom_range(0, 2) == 0) begin
            if (busy_list.size() > 0 && $urandom_range(0, 7) != 0)
               set_resp(1, busy_list[$urandom_range(0, busy_list.size() - 1)], cr);
            else
               set_resp(1, int'($urandom_range(0, 255)), cr);
         end else begin
            set_resp(0, 0, 0);
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
